mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmit peripheral on the processor's data-memory port, beside the data RAM.
- Decodes stores above the 4096-word RAM window and buffers the low byte of each store in a FIFO.
- Serializes buffered bytes onto a single TX line as 8N1 frames.
- Exposes a status word that the top level muxes into the processor's load data when the address hits the peripheral.

---
 rtl/mmio_uart_tx_if.sv | 20 ++
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
//   Data-memory-port bundle shared by the processor and the UART TX peripheral.
//   master: processor side (drives the store enable, address and data; receives the select and read data)
//   slave : peripheral side
//   Signals:
//     wren          processor store enable
//     address_dmem  processor word address
//     data          processor store data (the peripheral only uses [7:0])
//     mmio_sel      peripheral address hit (combinational)
//     q_mmio        peripheral read data (registered, 1-cycle latency)
interface mmio_uart_tx_if;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        mmio_sel;
  logic [31:0] q_mmio;

  modport master (output wren, address_dmem, data, input mmio_sel, q_mmio);
  modport slave  (input wren, address_dmem, data, output mmio_sel, q_mmio);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter that sits beside the data RAM.
//   - A store to MMIO_BASE pushes data[7:0] into a TX FIFO.
//     If the FIFO is full, the byte is dropped and the sticky overflow flag is set.
//   - A store to MMIO_BASE+1 clears the overflow flag.
//   - A read of MMIO_BASE+1 returns the status word one cycle later:
//       bit0 = empty, bit1 = full, bit2 = overflow, bit3 = busy,
//       bit4 = parity enabled, bits[15:8] = FIFO count.
//   - Bytes are sent LSB first as 8N1 frames, or as 8E1 frames when
//     MMIO_UART_PARITY_EN is defined.
//   Ports:
//     clock    system clock (rising edge)
//     reset    synchronous, active-high
//     bus      data-memory port bundle (slave modport)
//     uart_tx  serial line, idles high
//     tx_busy  high while a frame is in progress
//   Optional feature macro: MMIO_UART_PARITY_EN
module mmio_uart_tx #(
  parameter logic [31:0] MMIO_BASE    = 32'h0000_1000,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           uart_tx,
  output logic           tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PARITY_FLAG = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic PARITY_FLAG = 1'b0;
`endif

  state_t        state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_bit;
`ifdef MMIO_UART_PARITY_EN
  logic          parity_reg, parity_next;
`endif

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, count;
  logic          overflow_reg;
  logic [31:0]   q_mmio_reg;

  logic hit_data, hit_stat, empty, full, pop, push_req, push_ok, ovf_event, bit_end;
  logic [7:0]  rd_data;
  logic [31:0] status;

  assign hit_data = (bus.address_dmem == MMIO_BASE);
  assign hit_stat = (bus.address_dmem == MMIO_BASE + 32'd1);
  assign bus.mmio_sel = hit_data | hit_stat;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (count == '0);
  assign full  = count[AW];
  assign rd_data = fifo_mem[rd_ptr_reg[AW-1:0]];

  // Popping only from IDLE means a byte pushed into an empty FIFO is seen one
  // cycle later, never in the cycle it is written.
  assign pop       = (state_reg == IDLE) && !empty;
  assign push_req  = bus.wren && hit_data;
  assign push_ok   = push_req && (!full || pop);
  assign ovf_event = push_req && !push_ok;

  assign status = {16'h0000, 8'(count), 3'b000, PARITY_FLAG,
                   tx_busy, overflow_reg, full, empty};

  assign tx_busy    = (state_reg != IDLE);
  assign uart_tx    = tx_reg;
  assign bus.q_mmio = q_mmio_reg;
  assign bit_end    = (baud_reg == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.data[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
      q_mmio_reg   <= '0;
`ifdef MMIO_UART_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      // The line is registered, so it follows the state one cycle later.
      tx_reg      <= tx_bit;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      // A same-cycle overflow wins over a clear.
      if (ovf_event)                 overflow_reg <= 1'b1;
      else if (bus.wren && hit_stat) overflow_reg <= 1'b0;
      q_mmio_reg <= hit_stat ? status : 32'h0;
`ifdef MMIO_UART_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_bit       = 1'b1;
`ifdef MMIO_UART_PARITY_EN
    parity_next  = parity_reg;
`endif
    if (state_reg != IDLE) begin
      baud_next = bit_end ? '0 : baud_reg + CW'(1);
    end
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          shift_next = rd_data;
          baud_next  = '0;
          state_next = START;
`ifdef MMIO_UART_PARITY_EN
          parity_next = ^rd_data;
`endif
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        tx_bit = shift_reg[0];
        if (bit_end) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        tx_bit = parity_reg;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        tx_bit = 1'b1;
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef MMIO_UART_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic uart_tx, tx_busy;
  always #5 clock = ~clock;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.MMIO_BASE(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a byte queue plus the progress of the frame on the wire.
  logic [7:0]  mq[$];
  logic        m_ovf = 1'b0;
  logic        m_active = 1'b0;
  int          m_pos = 0;
  logic [7:0]  m_byte = 8'h00;
  logic        m_tx = 1'b1;
  logic [31:0] m_q = 32'h0;

  // Bit k of an on-the-wire frame: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    int   cnt;
    logic pop, ovf_ev;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0; m_active = 1'b0; m_pos = 0; m_tx = 1'b1; m_q = 32'h0;
      return;
    end
    cnt  = mq.size();
    m_q  = (a == BASE + 1) ? {16'h0, 8'(cnt), 3'b000, PAR, m_active, m_ovf,
                              (cnt == DEPTH), (cnt == 0)} : 32'h0;
    m_tx = m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1;
    pop  = !m_active && (cnt > 0);
    if (pop) begin
      m_byte = mq.pop_front(); m_active = 1'b1; m_pos = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == NBITS * CPB) m_active = 1'b0;
    end
    ovf_ev = 1'b0;
    if (w && a == BASE) begin
      if (cnt < DEPTH || pop) mq.push_back(d[7:0]);
      else ovf_ev = 1'b1;
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (w && a == BASE + 1) m_ovf = 1'b0;
  endtask

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    bus.wren = w; bus.address_dmem = a; bus.data = d; reset = r;
    #1;
    check32("mmio_sel", 32'(bus.mmio_sel), 32'((a == BASE) || (a == BASE + 1)));
    @(posedge clock);
    model_edge(w, a, d, r);
    #1;
    check32("uart_tx", 32'(uart_tx), 32'(m_tx));
    check32("tx_busy", 32'(tx_busy), 32'(m_active));
    check32("q_mmio", bus.q_mmio, m_q);
    $display("step w=%0b a=%h d=%h r=%0b tx=%0b busy=%0b q=%h", w, a, d, r, uart_tx, tx_busy, bus.q_mmio);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] ovf_word;
    ovf_word = 32'h0000_040E | {27'h0, PAR, 4'h0};

    // Reset and idle.
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle(20);
    step(1'b0, BASE + 1, 32'h0, 1'b0);
    check32("reset_status", bus.q_mmio, 32'h1 | {27'h0, PAR, 4'h0});

    // Single frame of 0x55.
    step(1'b1, BASE, 32'hFFFF_FF55, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check32("tx_before_start", 32'(uart_tx), 32'h1);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check32("start_bit", 32'(uart_tx), 32'h0);
    idle(NBITS * CPB + 4);

    // Three bytes back to back; keep polling status while they drain.
    step(1'b1, BASE, 32'h41, 1'b0);
    step(1'b1, BASE, 32'h42, 1'b0);
    step(1'b1, BASE, 32'h43, 1'b0);
    for (int i = 0; i < 3 * NBITS * CPB + 6; i++) step(1'b0, BASE + 1, 32'h0, 1'b0);

    // Overflow: six stores into a four-deep FIFO.
    for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'hA0 + 32'(i), 1'b0);
    step(1'b0, BASE + 1, 32'h0, 1'b0);
    check32("ovf_status", bus.q_mmio, ovf_word);
    step(1'b1, BASE + 1, 32'h0, 1'b0);
    step(1'b0, BASE + 1, 32'h0, 1'b0);
    check32("ovf_cleared", 32'(bus.q_mmio[2]), 32'h0);
    idle(5 * NBITS * CPB + 6);

    // Reset in the middle of a DATA bit.
    step(1'b1, BASE, 32'h3C, 1'b0);
    idle(4 * CPB);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check32("rst_tx", 32'(uart_tx), 32'h1);
    check32("rst_busy", 32'(tx_busy), 32'h0);
    step(1'b0, BASE + 1, 32'h0, 1'b0);
    check32("rst_status", bus.q_mmio, 32'h1 | {27'h0, PAR, 4'h0});

    // 0x07 exercises odd data bits (parity 1 when enabled).
    step(1'b1, BASE, 32'h07, 1'b0);
    idle(NBITS * CPB + 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: addr = BASE;
        1: addr = BASE + 1;
        2: addr = BASE + 2;
        default: addr = $urandom;
      endcase
      step(($urandom_range(0, 7) == 0), addr, $urandom, ($urandom_range(0, 499) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
